// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : graphics_pkg
//  Purpose  : Shared raster/sprite geometry and per-axis direction encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package graphics_pkg;

    localparam int C_VGA_WIDTH  = 640;
    localparam int C_VGA_HEIGHT = 480;
    localparam int C_SPRITE_W   = 272;
    localparam int C_SPRITE_H   = 168;

    // Value 0 is the increasing-coordinate direction on both axes.
    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_x_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_y_e;

endpackage
`default_nettype wire

// File: rtl/bounce_axis.sv
`default_nettype none
// ============================================================================
//  Module   : bounce_axis
//  Purpose  : One-axis step with clamp to [0, MAX_POS] and direction reversal.
//  Revision : 1.0 - initial release
// ============================================================================
module bounce_axis #(
    parameter int POS_W   = 10,
    parameter int MAX_POS = 368
) (
    input  logic [POS_W-1:0] i_pos,
    input  logic             i_dir_rev,
    input  logic [2:0]       i_speed,
    output logic [POS_W-1:0] o_pos,
    output logic             o_dir_rev,
    output logic             o_reversed
);

    localparam logic [POS_W:0] c_max = (POS_W+1)'(MAX_POS);

    logic [POS_W:0]   w_pos_ext;
    logic [POS_W:0]   w_speed_ext;
    logic [POS_W:0]   w_fwd;
    logic [POS_W-1:0] w_bwd;

    // Forward sum carries an extra bit so the compare sees the true value.
    assign w_pos_ext   = {1'b0, i_pos};
    assign w_speed_ext = (POS_W+1)'(i_speed);
    assign w_fwd       = w_pos_ext + w_speed_ext;
    assign w_bwd       = i_pos - POS_W'(i_speed);

    always_comb begin
        o_pos      = i_pos;
        o_dir_rev  = i_dir_rev;
        o_reversed = 1'b0;
        if (i_speed != 3'd0) begin
            if (!i_dir_rev) begin
                if (w_fwd >= c_max) begin
                    o_pos      = c_max[POS_W-1:0];
                    o_dir_rev  = 1'b1;
                    o_reversed = 1'b1;
                end else begin
                    o_pos = w_fwd[POS_W-1:0];
                end
            end else begin
                if (w_pos_ext <= w_speed_ext) begin
                    o_pos      = '0;
                    o_dir_rev  = 1'b0;
                    o_reversed = 1'b1;
                end else begin
                    o_pos = w_bwd;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_motion.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_motion
//  Purpose  : Frame-synchronous bouncing sprite position and animation cel.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_motion
    import graphics_pkg::*;
#(
    parameter int VGA_WIDTH       = C_VGA_WIDTH,
    parameter int VGA_HEIGHT      = C_VGA_HEIGHT,
    parameter int SPRITE_W        = C_SPRITE_W,
    parameter int SPRITE_H        = C_SPRITE_H,
    parameter int INIT_X          = 100,
    parameter int INIT_Y          = 100,
    parameter int FRAMES_PER_ANIM = 6,
    parameter int ANIM_FRAMES     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       enable,
    input  logic [2:0] speed,
    output logic [9:0] sprite_x,
    output logic [8:0] sprite_y,
    output logic [2:0] anim_frame,
    output logic       pos_update,
    output logic       bounce,
    output logic       corner
);

    localparam int c_max_x = VGA_WIDTH - SPRITE_W;
    localparam int c_max_y = VGA_HEIGHT - SPRITE_H;
    localparam int c_div_w = (FRAMES_PER_ANIM > 1) ? $clog2(FRAMES_PER_ANIM) : 1;

    logic [9:0]         r_x;
    logic [8:0]         r_y;
    dir_x_e             r_dir_x;
    dir_y_e             r_dir_y;
    logic [2:0]         r_anim;
    logic [c_div_w-1:0] r_div;
    logic               r_fs_prev;
    logic               r_pos_update;
    logic               r_bounce;
    logic               r_corner;

    logic       w_go;
    logic [9:0] w_nx;
    logic [8:0] w_ny;
    logic       w_nx_rev;
    logic       w_ny_rev;
    logic       w_rev_x;
    logic       w_rev_y;

    // A held frame_start counts once: only its rising edge qualifies.
    assign w_go = frame_start & ~r_fs_prev & enable;

    bounce_axis #(
        .POS_W   (10),
        .MAX_POS (c_max_x)
    ) u_axis_x (
        .i_pos      (r_x),
        .i_dir_rev  (r_dir_x == DIR_LEFT),
        .i_speed    (speed),
        .o_pos      (w_nx),
        .o_dir_rev  (w_nx_rev),
        .o_reversed (w_rev_x)
    );

    bounce_axis #(
        .POS_W   (9),
        .MAX_POS (c_max_y)
    ) u_axis_y (
        .i_pos      (r_y),
        .i_dir_rev  (r_dir_y == DIR_UP),
        .i_speed    (speed),
        .o_pos      (w_ny),
        .o_dir_rev  (w_ny_rev),
        .o_reversed (w_rev_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= 10'(INIT_X);
            r_y          <= 9'(INIT_Y);
            r_dir_x      <= DIR_RIGHT;
            r_dir_y      <= DIR_DOWN;
            r_anim       <= 3'd0;
            r_div        <= '0;
            // Tracking frame_start through reset masks a pulse held across release.
            r_fs_prev    <= frame_start;
            r_pos_update <= 1'b0;
            r_bounce     <= 1'b0;
            r_corner     <= 1'b0;
        end else begin
            r_fs_prev    <= frame_start;
            r_pos_update <= w_go;
            r_bounce     <= w_go & (w_rev_x | w_rev_y);
            r_corner     <= w_go & w_rev_x & w_rev_y;
            if (w_go) begin
                r_x     <= w_nx;
                r_y     <= w_ny;
                r_dir_x <= w_nx_rev ? DIR_LEFT : DIR_RIGHT;
                r_dir_y <= w_ny_rev ? DIR_UP : DIR_DOWN;
                if (r_div == c_div_w'(FRAMES_PER_ANIM - 1)) begin
                    r_div  <= '0;
                    r_anim <= (r_anim == 3'(ANIM_FRAMES - 1)) ? 3'd0 : r_anim + 3'd1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign sprite_x   = r_x;
    assign sprite_y   = r_y;
    assign anim_frame = r_anim;
    assign pos_update = r_pos_update;
    assign bounce     = r_bounce;
    assign corner     = r_corner;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_motion
//  Purpose  : Directed self-checking bench for sprite_motion.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_motion;

    logic       clk = 1'b0;
    logic       rst, frame_start, enable;
    logic [2:0] speed;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic [2:0] anim_frame;
    logic       pos_update, bounce, corner;

    logic       rst2, frame_start2, enable2;
    logic [2:0] speed2;
    logic [9:0] sprite_x2;
    logic [8:0] sprite_y2;
    logic [2:0] anim_frame2;
    logic       pos_update2, bounce2, corner2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_motion u_dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .enable     (enable),
        .speed      (speed),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .anim_frame (anim_frame),
        .pos_update (pos_update),
        .bounce     (bounce),
        .corner     (corner)
    );

    // Small playfield (MAX_X = 21, MAX_Y = 20) so both axes hit their limits together.
    sprite_motion #(
        .VGA_WIDTH (293),
        .VGA_HEIGHT(188),
        .INIT_X    (11),
        .INIT_Y    (10)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst2),
        .frame_start(frame_start2),
        .enable     (enable2),
        .speed      (speed2),
        .sprite_x   (sprite_x2),
        .sprite_y   (sprite_y2),
        .anim_frame (anim_frame2),
        .pos_update (pos_update2),
        .bounce     (bounce2),
        .corner     (corner2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fs1(input logic [2:0] s);
        @(negedge clk);
        speed       = s;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic fs2(input logic [2:0] s);
        @(negedge clk);
        speed2       = s;
        frame_start2 = 1'b1;
        @(negedge clk);
        frame_start2 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; frame_start = 1'b0; enable = 1'b1; speed = 3'd0;
        rst2 = 1'b1; frame_start2 = 1'b0; enable2 = 1'b1; speed2 = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_x", sprite_x, 100);
        chk("reset_y", sprite_y, 100);
        chk("reset_anim", anim_frame, 0);
        chk("reset_pulses", {pos_update, bounce, corner}, 0);
        rst = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        // First move at speed 3
        fs1(3'd3);
        chk("first_x", sprite_x, 103);
        chk("first_y", sprite_y, 103);
        chk("first_pos_update", pos_update, 1);
        chk("first_bounce", bounce, 0);
        @(negedge clk);
        chk("pos_update_one_cycle", pos_update, 0);

        // Speed changes without frame_start do nothing
        speed = 3'd7;
        repeat (3) @(negedge clk);
        chk("speed_idle_x", sprite_x, 103);

        // A frame_start held four cycles is one event
        frame_start = 1'b1;
        repeat (4) @(negedge clk);
        frame_start = 1'b0;
        chk("held_fs_x", sprite_x, 110);
        chk("held_fs_pulse", pos_update, 0);

        // 35 more steps of 7; y clamps at 312 on step 30
        for (int k = 2; k <= 36; k++) begin
            fs1(3'd7);
            chk($sformatf("run_bounce_%0d", k), bounce, (k == 30) ? 1 : 0);
            if (k == 30) chk("y_clamp", sprite_y, 312);
        end
        chk("run_x", sprite_x, 355);
        chk("run_y", sprite_y, 270);

        fs1(3'd6);
        chk("pre_edge_x", sprite_x, 361);
        chk("pre_edge_y", sprite_y, 264);

        fs1(3'd7);
        chk("edge_x", sprite_x, 368);
        chk("edge_y", sprite_y, 257);
        chk("edge_bounce", bounce, 1);
        chk("edge_corner", corner, 0);

        fs1(3'd7);
        chk("after_edge_x", sprite_x, 361);
        chk("after_edge_y", sprite_y, 250);
        chk("after_edge_bounce", bounce, 0);

        // Reset overrides a coincident frame_start and its continuation
        @(negedge clk);
        rst = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        chk("rst_fs_x", sprite_x, 100);
        chk("rst_fs_y", sprite_y, 100);
        chk("rst_fs_pulses", {pos_update, bounce, corner}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_pulse", pos_update, 0);
        chk("rst_release_x", sprite_x, 100);
        frame_start = 1'b0;
        @(negedge clk);

        // Speed 0: position fixed, animation steps every 6 frames
        for (int k = 1; k <= 36; k++) begin
            fs1(3'd0);
            chk($sformatf("still_x_%0d", k), sprite_x, 100);
            chk($sformatf("still_bounce_%0d", k), bounce, 0);
            chk($sformatf("still_anim_%0d", k), anim_frame, (k / 6) % 6);
        end

        // Disabled frames are ignored entirely, including the divider
        enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            fs1(3'd5);
            chk($sformatf("dis_pulse_%0d", k), pos_update, 0);
        end
        chk("dis_x", sprite_x, 100);
        chk("dis_y", sprite_y, 100);
        enable = 1'b1;
        repeat (5) fs1(3'd0);
        chk("div_kept_anim5", anim_frame, 0);
        fs1(3'd0);
        chk("div_kept_anim6", anim_frame, 1);

        // Small field: corner at max, then corner at zero from (2,1)
        fs2(3'd5);
        chk("s_x1", sprite_x2, 16);
        chk("s_y1", sprite_y2, 15);
        fs2(3'd5);
        chk("s_max_x", sprite_x2, 21);
        chk("s_max_y", sprite_y2, 20);
        chk("s_max_corner", {bounce2, corner2}, 2'b11);
        fs2(3'd5);
        fs2(3'd5);
        fs2(3'd5);
        chk("s_back_x", sprite_x2, 6);
        fs2(3'd4);
        chk("s_pre_x", sprite_x2, 2);
        chk("s_pre_y", sprite_y2, 1);
        fs2(3'd4);
        chk("s_zero_x", sprite_x2, 0);
        chk("s_zero_y", sprite_y2, 0);
        chk("s_zero_corner", {bounce2, corner2}, 2'b11);
        fs2(3'd4);
        chk("s_turn_x", sprite_x2, 4);
        chk("s_turn_y", sprite_y2, 4);
        chk("s_turn_corner", {bounce2, corner2}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_motion.md
SPRITE_MOTION -- requirements
Module: sprite_motion

Interface
REQ-001 SHALL have parameter VGA_WIDTH, default 640, visible pixels per line.
REQ-002 SHALL have parameter VGA_HEIGHT, default 480, visible lines per frame.
REQ-003 SHALL have parameter SPRITE_W, default 272, sprite width in pixels.
REQ-004 SHALL have parameter SPRITE_H, default 168, sprite height in pixels.
REQ-005 SHALL have parameter INIT_X, default 100, and INIT_Y, default 100, the reset position.
REQ-006 SHALL have parameter FRAMES_PER_ANIM, default 6, video frames per animation step.
REQ-007 SHALL have parameter ANIM_FRAMES, default 6, animation cels in the cycle.
REQ-008 SHALL have port clk, input, 1 bit, the single pixel clock.
REQ-009 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-010 SHALL have port frame_start, input, 1 bit, one-cycle pulse issued when the raster wraps to line 0.
REQ-011 SHALL have port enable, input, 1 bit; low freezes motion and animation.
REQ-012 SHALL have port speed, input, 3 bits, step in pixels per frame on each axis.
REQ-013 SHALL have port sprite_x, output, 10 bits, left edge of the sprite.
REQ-014 SHALL have port sprite_y, output, 9 bits, top edge of the sprite.
REQ-015 SHALL have port anim_frame, output, 3 bits, current cel index.
REQ-016 SHALL have port pos_update, output, 1 bit, one-cycle pulse when the outputs change.
REQ-017 SHALL have port bounce, output, 1 bit, one-cycle pulse on any edge reversal.
REQ-018 SHALL have port corner, output, 1 bit, one-cycle pulse when both axes reverse in the same update.

Function
REQ-019 SHALL change sprite_x, sprite_y and anim_frame only in the cycle after frame_start is sampled high with enable high (latency 1), so the raster never tears.
REQ-020 SHALL assert pos_update in that same cycle, and only then.
REQ-021 SHALL sample speed only at frame_start; changes between frames have no effect.
REQ-022 SHALL hold per-axis direction state: X in {RIGHT, LEFT}, Y in {DOWN, UP}.
REQ-023 Forward move: SHALL take next = pos + speed; if next >= MAX, output MAX and reverse direction. MAX_X = VGA_WIDTH-SPRITE_W (368); MAX_Y = VGA_HEIGHT-SPRITE_H (312).
REQ-024 Backward move: if pos <= speed, SHALL output 0 and reverse; otherwise output pos - speed.
REQ-025 Arithmetic SHALL be one bit wider than the position so no wrap-around occurs before the compare.
REQ-026 With speed = 0, SHALL leave the position unchanged and never reverse, while animation continues.
REQ-027 SHALL pulse bounce for one cycle, coincident with pos_update, when either axis reverses.
REQ-028 SHALL pulse corner, together with bounce, when both axes reverse in the same update.
REQ-029 Animation: a divider SHALL count qualifying frame_starts from 0 to FRAMES_PER_ANIM-1; on wrap, anim_frame SHALL increment modulo ANIM_FRAMES (5 -> 0).
REQ-030 With enable low, SHALL ignore frame_start: no position change, no divider change and no pulses.
REQ-031 SHALL treat frame_start asserted for more than one cycle as a single event, rising-edge qualified.

Reset
REQ-032 On rst high at a clk edge: sprite_x = INIT_X, sprite_y = INIT_Y, directions RIGHT/DOWN, anim_frame = 0, divider = 0, all pulses 0.
REQ-033 Reset SHALL override a simultaneous frame_start; a frame_start coincident with reset deassertion SHALL be ignored.
REQ-034 Reset asserted mid-animation SHALL discard the divider count with no residual pulse.

Structure
REQ-035 SHALL take VGA_WIDTH, VGA_HEIGHT, SPRITE_W, SPRITE_H and the direction encodings from shared package graphics_pkg.
REQ-036 SHALL implement per-axis clamp/reverse logic in sub-module bounce_axis, instantiated once for X and once for Y.
REQ-037 SHALL register every output; there SHALL be no combinational path from input to output.

Verification
REQ-038 Reset, then one frame_start at speed 3 -> after 1 cycle x = 103, y = 103, pos_update = 1, bounce = 0.
REQ-039 x = 361, RIGHT, speed 7, frame_start -> x = 368, direction LEFT, bounce = 1; next frame x = 361.
REQ-040 x = 2, y = 1, LEFT/UP, speed 4, frame_start -> x = 0, y = 0, bounce = 1, corner = 1, directions RIGHT/DOWN.
REQ-041 36 frame_starts at speed 0 -> position constant, anim_frame sequence 0,1,2,3,4,5,0, no bounce.
REQ-042 enable low over 10 frame_starts -> no pos_update, outputs unchanged; rst together with frame_start -> reset values, no pulse.
